// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-read-port general register file with EX-priority write port,
//   JTAG debug port, post-reset zeroing sequencer and a per-register
//   pending scoreboard used by ID for RAW hazard detection.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : read ports forward same-cycle EX write data and mask pend_o
//     undefined : reads return the stored value only
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     we_i/waddr_i/wdata_i      EX/WB write port (priority)
//     jtag_we_i/jtag_addr_i     JTAG write enable / read-write address
//     jtag_data_i/jtag_data_o   JTAG write data / read data (never forwarded)
//     jtag_busy_o               a JTAG write this cycle would be dropped
//     raddr_i/rdata_o           packed read addresses / read data
//     pend_o                    per-read-port outstanding-write flag
//     pend_set_i/pend_addr_i    ID issue: mark destination register pending
//     flush_i                   clear the whole scoreboard
//     init_busy_o               zeroing sequencer active
//
//   State   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | zeroing regs[1..DEPTH-1], one per cycle; all requests ignored
//   ST_RUN  | normal operation
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic                         jtag_we_i,
  input  logic [ADDR_W-1:0]            jtag_addr_i,
  input  logic [DATA_W-1:0]            jtag_data_i,
  output logic [DATA_W-1:0]            jtag_data_o,
  output logic                         jtag_busy_o,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
  output logic [RD_PORTS*DATA_W-1:0]   rdata_o,
  output logic [RD_PORTS-1:0]          pend_o,
  input  logic                         pend_set_i,
  input  logic [ADDR_W-1:0]            pend_addr_i,
  input  logic                         flush_i,
  output logic                         init_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [DEPTH-1:0]    r_pend;

  logic                w_init;
  logic                w_ex_hit_addr;
  logic                w_ex_we;
  logic                w_jtag_we;
  logic [DEPTH-1:0]    w_pend_nxt;

  assign w_init        = (r_state == ST_INIT);
  assign w_ex_hit_addr = we_i & (waddr_i != '0);
  assign w_ex_we       = ~w_init & w_ex_hit_addr;
  // JTAG only wins a free cycle: any real EX write drops it, no retry.
  assign w_jtag_we     = ~w_init & jtag_we_i & (jtag_addr_i != '0) & ~w_ex_hit_addr;

  assign init_busy_o = w_init;
  assign jtag_busy_o = w_init | w_ex_hit_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= ADDR_W'(1);
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + ADDR_W'(1);
      if (r_cnt == {ADDR_W{1'b1}}) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Storage has no reset of its own; the sequencer clears it after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init) begin
        r_regs[r_cnt] <= '0;
      end else if (w_ex_we) begin
        r_regs[waddr_i] <= wdata_i;
      end else if (w_jtag_we) begin
        r_regs[jtag_addr_i] <= jtag_data_i;
      end
    end
  end

  // Clear first, then set, so a same-address issue keeps the bit pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_ex_we) begin
      w_pend_nxt[waddr_i] = 1'b0;
    end
    if (pend_set_i) begin
      w_pend_nxt[pend_addr_i] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (!w_init) begin
      if (flush_i) begin
        r_pend <= '0;
      end else begin
        r_pend <= w_pend_nxt;
      end
    end
  end

  assign jtag_data_o = (w_init || jtag_addr_i == '0) ? '0 : r_regs[jtag_addr_i];

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_fwd;

    assign w_ra = raddr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign w_fwd = w_ex_we & (w_ra == waddr_i);
`else
    assign w_fwd = 1'b0;
`endif
    assign rdata_o[k*DATA_W +: DATA_W] = (w_init || w_ra == '0) ? '0 :
                                         w_fwd ? wdata_i : r_regs[w_ra];
    assign pend_o[k] = ~w_init & r_pend[w_ra] & ~w_fwd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int RP    = 2;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_i;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] wdata_i;
  logic          jtag_we_i;
  logic [AW-1:0] jtag_addr_i;
  logic [DW-1:0] jtag_data_i;
  logic [DW-1:0] jtag_data_o;
  logic          jtag_busy_o;
  logic [RP*AW-1:0] raddr_i;
  logic [RP*DW-1:0] rdata_o;
  logic [RP-1:0] pend_o;
  logic          pend_set_i;
  logic [AW-1:0] pend_addr_i;
  logic          flush_i;
  logic          init_busy_o;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .jtag_we_i(jtag_we_i), .jtag_addr_i(jtag_addr_i), .jtag_data_i(jtag_data_i),
    .jtag_data_o(jtag_data_o), .jtag_busy_o(jtag_busy_o), .raddr_i(raddr_i),
    .rdata_o(rdata_o), .pend_o(pend_o), .pend_set_i(pend_set_i),
    .pend_addr_i(pend_addr_i), .flush_i(flush_i), .init_busy_o(init_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ib;
    logic          jb;
    logic [DW-1:0] jd;
    logic [RP*DW-1:0] rd;
    logic [RP-1:0] pd;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents, pending set, remaining init cycles.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend[DEPTH];
  int            m_init_left;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  // Advance the model across one clock edge using the inputs held before it.
  function automatic void model_step();
    bit ex;
    if (rst) begin
      m_init_left = DEPTH - 1;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      ex = we_i && waddr_i != 0;
      if (ex) m_mem[waddr_i] = wdata_i;
      else if (jtag_we_i && jtag_addr_i != 0) m_mem[jtag_addr_i] = jtag_data_i;
      if (flush_i) begin
        foreach (m_pend[i]) m_pend[i] = 0;
      end else begin
        if (ex) m_pend[waddr_i] = 0;
        if (pend_set_i && pend_addr_i != 0) m_pend[pend_addr_i] = 1;
      end
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    bit init, ex, fwd;
    int a;
    init = (m_init_left > 0);
    ex   = !init && we_i && waddr_i != 0;
    e.ib = init;
    e.jb = init || (we_i && waddr_i != 0);
    e.jd = (init || jtag_addr_i == 0) ? '0 : m_mem[jtag_addr_i];
    e.rd = '0;
    e.pd = '0;
    for (int k = 0; k < RP; k++) begin
      a = int'(raddr_i[k*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
      fwd = ex && (a == int'(waddr_i));
`else
      fwd = 0;
`endif
      if (!init && a != 0) e.rd[k*DW +: DW] = fwd ? wdata_i : m_mem[a];
      e.pd[k] = !init && m_pend[a] && !fwd;
    end
    q.push_back(e);
  endfunction

  task automatic apply(input logic r, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic jw, input logic [AW-1:0] ja,
                       input logic [DW-1:0] jd, input logic [AW-1:0] ra0,
                       input logic [AW-1:0] ra1, input logic ps,
                       input logic [AW-1:0] pa, input logic fl);
    @(posedge clk);
    model_step();
    #1;
    rst = r; we_i = w; waddr_i = wa; wdata_i = wd;
    jtag_we_i = jw; jtag_addr_i = ja; jtag_data_i = jd;
    raddr_i = {ra1, ra0}; pend_set_i = ps; pend_addr_i = pa; flush_i = fl;
    push_expected();
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    apply(0, 0, 0, 0, 0, 0, 0, ra0, ra1, 0, 0, 0);
  endtask

  task automatic count_init(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!init_busy_o) break;
      n++;
      idle(0, 0);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) idle(AW'(a), AW'(DEPTH - 1 - a));
  endtask

  task automatic rand_cycle(input int flush_div);
    apply(0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
          1'($urandom_range(0, 1)), AW'($urandom), $urandom,
          AW'($urandom), AW'($urandom), 1'($urandom_range(0, 2) == 0),
          AW'($urandom), 1'($urandom_range(0, flush_div - 1) == 0));
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("init_busy", 64'(init_busy_o), 64'(e.ib));
        check("jtag_busy", 64'(jtag_busy_o), 64'(e.jb));
        check("jtag_data", 64'(jtag_data_o), 64'(e.jd));
        check("rdata",     64'(rdata_o),     64'(e.rd));
        check("pend",      64'(pend_o),      64'(e.pd));
      end
    end
  end

  initial begin
    int n;
    rst = 1; we_i = 0; waddr_i = 0; wdata_i = 0; jtag_we_i = 0; jtag_addr_i = 0;
    jtag_data_i = 0; raddr_i = 0; pend_set_i = 0; pend_addr_i = 0; flush_i = 0;
    m_init_left = DEPTH - 1;
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_pend[i]) m_pend[i] = 0;

    repeat (3) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_init_busy", 64'(init_busy_o), 64'd1);
    check("reset_jtag_busy", 64'(jtag_busy_o), 64'd1);

    idle(0, 0);
    count_init(n);
    check("init_len", 64'(n), 64'd31);
    read_all();

    repeat (60) rand_cycle(16);

    // Reset again, attempt EX writes during INIT, then restart mid-INIT.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      apply(0, 1, AW'(i + 1), $urandom, 1, AW'(i + 3), $urandom, AW'(i + 1), 0, 1, AW'(i + 1), 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    count_init(n);
    check("init_len_restart", 64'(n), 64'd31);
    read_all();

    // EX/JTAG collision on x5, then free JTAG write to x6.
    apply(0, 1, 5, 32'hDEADBEEF, 1, 5, 32'h12345678, 5, 5, 0, 0, 0);
    #1 check("collide_jtag_busy", 64'(jtag_busy_o), 64'd1);
    apply(0, 0, 0, 0, 1, 6, 32'hA5A5A5A5, 5, 6, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 6, 0, 5, 6, 0, 0, 0);
    #1;
    check("x5_ex_wins", 64'(rdata_o[31:0]), 64'hDEADBEEF);
    check("jtag_x6", 64'(jtag_data_o), 64'hA5A5A5A5);

    // Writes and scoreboard on x0 have no effect.
    apply(0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0);
    idle(0, 0);
    #1;
    check("x0_reads_zero", 64'(rdata_o), 64'd0);
    check("x0_not_pending", 64'(pend_o), 64'd0);

    // Scoreboard set / set-beats-clear / flush.
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle(0, 7);
    #1 check("pend7_set", 64'(pend_o[1]), 64'd1);
    apply(0, 1, 7, 32'h55, 0, 0, 0, 0, 7, 1, 7, 0);
    idle(0, 7);
    #1 check("pend7_set_wins", 64'(pend_o[1]), 64'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1);
    idle(0, 7);
    #1 check("pend7_flushed", 64'(pend_o[1]), 64'd0);

    // Same-cycle write/read collision on x9.
    apply(0, 1, 9, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    apply(0, 1, 9, 32'h77, 0, 0, 0, 9, 0, 0, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x9_same_cycle", 64'(rdata_o[31:0]), 64'h77);
    check("x9_pend_same_cycle", 64'(pend_o[0]), 64'd0);
`else
    check("x9_same_cycle", 64'(rdata_o[31:0]), 64'h11);
    check("x9_pend_same_cycle", 64'(pend_o[0]), 64'd1);
`endif
    idle(9, 0);
    #1;
    check("x9_next_cycle", 64'(rdata_o[31:0]), 64'h77);
    check("x9_pend_next_cycle", 64'(pend_o[0]), 64'd0);

    repeat (3000) rand_cycle(8);
    read_all();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port general register file for the core, the next generation of the two-read-port register file. It has a configurable data width, depth and read-port count, and keeps the EX-priority write and JTAG debug ports. It adds a post-reset hardware zeroing sequencer and a per-register pending scoreboard that lets ID detect RAW hazards. It sits between ID (read ports, issue), EX/WB (write port) and the JTAG debug module.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers; register 0 is hardwired zero
- RD_PORTS, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; the block uses one clock
- rst  in  1  reset; synchronous, active-high
- we_i  in  1  EX/WB write enable
- waddr_i  in  ADDR_W  EX/WB write address
- wdata_i  in  DATA_W  EX/WB write data
- jtag_we_i  in  1  JTAG write enable
- jtag_addr_i  in  ADDR_W  JTAG read/write address
- jtag_data_i  in  DATA_W  JTAG write data
- jtag_data_o  out  DATA_W  JTAG read data
- jtag_busy_o  out  1  a JTAG write in this cycle will be dropped
- raddr_i  in  RD_PORTS*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- rdata_o  out  RD_PORTS*DATA_W  read data, packed the same way
- pend_o  out  RD_PORTS  register addressed by read port k has an outstanding write
- pend_set_i  in  1  ID issued an instruction that will write pend_addr_i
- pend_addr_i  in  ADDR_W  destination register of the issued instruction
- flush_i  in  1  clear all pending bits (pipeline flush)
- init_busy_o  out  1  zeroing sequencer active

## Operation
State machine states are INIT and RUN.
- While rst is high: state=INIT, init counter=1, all pending bits=0.
- INIT:
  - Each cycle writes 0 to regs[counter], then increments the counter.
  - When counter==DEPTH-1 is written, the next state is RUN.
  - EX, JTAG and pend_set_i requests are ignored.
- RUN: normal operation.
- rst asserted at any point, including mid-INIT, restarts INIT from counter=1.

Writes (RUN only; address 0 is never written):
- EX write has priority.
- A JTAG write is performed only when it does not collide with an EX write (we_i=0 or waddr_i=0). Otherwise it is dropped with no retry.
- jtag_busy_o = init_busy_o | (we_i & waddr_i!=0).

Reads (combinational):
- Address 0 returns 0.
- During INIT every read port and jtag_data_o returns 0.
- Otherwise a read returns regs[addr], or the forwarded value (see Configuration).
- jtag_data_o is never forwarded.

Scoreboard (DEPTH bits; bit 0 is constant 0; updates only in RUN):
- An EX write to address a clears bit a.
- pend_set_i sets bit pend_addr_i.
- Set and clear of the same address in one cycle: set wins.
- flush_i clears all bits and overrides a simultaneous pend_set_i.
- JTAG writes do not affect the scoreboard.
- pend_o[k] = pend[raddr_k], masked as described under Configuration.

## Timing
- Reset values:
  - init_busy_o=1.
  - jtag_busy_o=1.
  - rdata_o=0.
  - jtag_data_o=0.
  - pend_o=0.
- init_busy_o stays 1 for exactly DEPTH-1 cycles after the first clk edge with rst=0 (31 cycles at default), then drops.
- Write latency: a write is stored at the clk edge. Without forwarding, the value is visible on reads the following cycle.
- Scoreboard latency: a pend_set_i edge affects pend_o in the next cycle. The clear from an EX write takes effect at the same edge as the register write.
- All read outputs are combinational from raddr_i, the current-cycle write inputs and state; there are no registered outputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose address equals a nonzero waddr_i with we_i=1 (in RUN) returns wdata_i in the same cycle.
  - pend_o[k] is forced to 0 for that port in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; reads return the stored value.
  - pend_o[k] follows the registered bit, so it deasserts one cycle after the write edge.
  - ID must stall one extra cycle on a same-cycle write/read collision.

## Test plan
- Reset, then release rst: init_busy_o=1 for 31 cycles; afterwards every address reads 0 and jtag_busy_o=0 with no EX write.
- Pulse rst at INIT cycle 10 after EX writes were attempted: INIT restarts from counter 1, takes a further 31 cycles, and all registers read 0.
- RUN, EX write x5=0xDEADBEEF and JTAG write x5=0x12345678 in the same cycle: x5=0xDEADBEEF and jtag_busy_o=1. Next cycle JTAG write x6=0xA5A5A5A5: jtag_data_o at addr 6 reads 0xA5A5A5A5.
- EX write x0=0xFFFFFFFF, and JTAG write x0: all ports still read 0 at addr 0; pend_set_i with addr 0 leaves pend_o=0.
- pend_set_i x7; next cycle raddr port1=7 gives pend_o[1]=1. EX write x7=0x55 together with pend_set_i x7: the bit stays 1. Then flush_i: pend_o[1]=0.
- Read port0=9 while EX writes x9=0x77: with REGFILE_BYPASS_EN, rdata port0=0x77 and pend_o[0]=0 in the same cycle. Without it, the old value is returned that cycle and 0x77 the next.
